// File: rtl/ioctl_dl_bridge.sv
// Bridges the hps_io ioctl download stream into a byte FIFO and drains it to core
// memory over a req/ack write port, routing each download to one of N_CH targets.
module ioctl_dl_bridge #(
   parameter int ADDR_W     = 25,
   parameter int FIFO_DEPTH = 16,
   parameter int N_CH       = 4,
   parameter int WAIT_LVL   = FIFO_DEPTH - 2,
   localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [ADDR_W-1:0] ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              ioctl_wait,
   output logic              mem_req,
   input  logic              mem_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic [CH_W-1:0]   mem_ch,
   output logic              busy,
   output logic              done,
   output logic              err_ovf,
   output logic [ADDR_W-1:0] byte_cnt,
   output logic [7:0]        xsum
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

   state_t state, state_nx;

   logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
   logic [7:0]        fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    fill, fill_nx;
   logic              full, empty, pop, push_try, push, drop, start, wait_nx;

   always_comb begin
      full     = (fill == (PTR_W+1)'(FIFO_DEPTH));
      empty    = (fill == '0);
      pop      = mem_req && mem_ack;
      push_try = (state == S_LOAD) && ioctl_wr;
      push     = push_try && (!full || pop);
      drop     = push_try && !push;
      start    = (state == S_IDLE) && ioctl_download && (32'(ioctl_index) < 32'(N_CH));
      fill_nx  = fill + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
   end

   always_ff @(posedge clk_sys) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_LOAD;
         S_LOAD:  if (!ioctl_download) state_nx = S_DRAIN;
         S_DRAIN: if (empty && !mem_req) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == S_LOAD) || (state == S_DRAIN);
      done = (state == S_DONE);
   end

   // Wait is derived from next-cycle state and fill so it rises the cycle after the push that crosses WAIT_LVL.
   always_comb begin
      wait_nx = ((state_nx == S_LOAD) && (fill_nx >= (PTR_W+1)'(WAIT_LVL))) ||
                (((state_nx == S_DRAIN) || (state_nx == S_DONE)) && ioctl_download);
   end

   always_ff @(posedge clk_sys) begin
      if (push) begin
         fifo_addr[wr_ptr] <= ioctl_addr;
         fifo_data[wr_ptr] <= ioctl_dout;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill       <= '0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= '0;
         mem_ch     <= '0;
         err_ovf    <= 1'b0;
         byte_cnt   <= '0;
         xsum       <= '0;
         ioctl_wait <= 1'b0;
      end else begin
         fill       <= fill_nx;
         ioctl_wait <= wait_nx;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         // Head entry stays in the FIFO until acked, so fill includes the word on the mem port.
         if (pop) begin
            rd_ptr  <= rd_ptr + PTR_W'(1);
            mem_req <= 1'b0;
         end else if (!mem_req && !empty) begin
            mem_req  <= 1'b1;
            mem_addr <= fifo_addr[rd_ptr];
            mem_data <= fifo_data[rd_ptr];
         end
         if (start) begin
            mem_ch   <= ioctl_index[CH_W-1:0];
            byte_cnt <= '0;
            xsum     <= '0;
            err_ovf  <= 1'b0;
         end else begin
            if (push) begin
               if (byte_cnt != '1) byte_cnt <= byte_cnt + ADDR_W'(1);
               xsum <= xsum + ioctl_dout;
            end
            if (drop) err_ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ioctl_dl_bridge.sv
// Self-checking bench for ioctl_dl_bridge: vector table of whole downloads, hand-written
// reset / back-to-back sequences, and randomized downloads against a queue reference model.
module tb_ioctl_dl_bridge;

   localparam int ADDR_W = 25;
   localparam int DEPTH  = 16;
   localparam int N_CH   = 4;
   localparam int WLVL   = 14;

   logic              clk_sys = 1'b0;
   logic              reset = 1'b1;
   logic              ioctl_download = 1'b0;
   logic [7:0]        ioctl_index = '0;
   logic              ioctl_wr = 1'b0;
   logic [ADDR_W-1:0] ioctl_addr = '0;
   logic [7:0]        ioctl_dout = '0;
   logic              ioctl_wait;
   logic              mem_req;
   logic              mem_ack = 1'b0;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic [1:0]        mem_ch;
   logic              busy, done, err_ovf;
   logic [ADDR_W-1:0] byte_cnt;
   logic [7:0]        xsum;

   ioctl_dl_bridge #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .N_CH(N_CH), .WAIT_LVL(WLVL)) dut (
      .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
      .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_ch(mem_ch), .busy(busy), .done(done), .err_ovf(err_ovf), .byte_cnt(byte_cnt), .xsum(xsum)
   );

   always #5 clk_sys = ~clk_sys;

   int n_vec = 0;
   int n_bad = 0;
   int unsigned cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   // memory-side ack: fixed level or random per cycle
   bit ack_rand = 1'b0;
   bit ack_lvl  = 1'b0;
   always @(posedge clk_sys) begin
      #2;
      mem_ack = ack_rand ? 1'($urandom) : ack_lvl;
   end

   // monitor: accepted mem writes, done pulses, stability of a pending request
   logic [ADDR_W+7:0] got_q[$];
   int unsigned       got_t[$];
   int                done_cnt = 0;
   int                stab_err = 0;
   logic              p_req = 1'b0, p_ack = 1'b0;
   logic [ADDR_W+7:0] p_word = '0;
   always @(negedge clk_sys) begin
      if (mem_req && mem_ack) begin
         got_q.push_back({mem_addr, mem_data});
         got_t.push_back(cyc);
      end
      if (p_req && !p_ack && mem_req && (p_word != {mem_addr, mem_data})) stab_err++;
      if (done) done_cnt++;
      p_req  = mem_req;
      p_ack  = mem_ack;
      p_word = {mem_addr, mem_data};
   end

   logic [ADDR_W-1:0] tx_a[$];
   logic [7:0]        tx_d[$];

   typedef struct {
      logic [7:0] idx;
      int         n;
      logic [7:0] base;
      bit         ack;
      bit         honour;
      int         exp_cnt;
      logic [7:0] exp_xsum;
      bit         exp_ovf;
      int         exp_wait_at;
      bit         chk_rate;
   } vec_t;

   vec_t tab[6];

   task automatic step;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // raise the download, then push tx_a/tx_d, optionally honouring ioctl_wait
   task automatic run_load(input logic [7:0] idx, input bit honour, input bit gaps, input string tag,
                           output int wait_at, output int unsigned first_cyc);
      int i, guard, wait_hi;
      ioctl_index = idx;
      ioctl_download = 1'b1;
      step;
      for (int b = 0; b < 10 && !busy; b++) step;
      check({tag, ".load_entry"}, 64'(busy), 64'd1);
      wait_at = -1;
      first_cyc = 0;
      i = 0; guard = 0; wait_hi = 0;
      while (i < tx_d.size() && guard < 3000) begin
         guard++;
         if (ioctl_wait && wait_at < 0) wait_at = i;
         if (ioctl_wait) wait_hi++;
         if (honour && wait_hi > 8) ack_lvl = 1'b1;
         if ((honour && ioctl_wait) || (gaps && $urandom_range(0, 3) == 0)) begin
            ioctl_wr = 1'b0;
         end else begin
            if (i == 0) first_cyc = cyc;
            ioctl_wr = 1'b1;
            ioctl_addr = tx_a[i];
            ioctl_dout = tx_d[i];
            i++;
         end
         step;
      end
      ioctl_wr = 1'b0;
      check({tag, ".writes_issued"}, 64'(i), 64'(tx_d.size()));
   endtask

   task automatic finish_dl(input int d0, input string tag);
      ioctl_download = 1'b0;
      ack_rand = 1'b0;
      ack_lvl = 1'b1;
      step;
      for (int c = 0; c < 800 && busy; c++) step;
      step;
      step;
      check({tag, ".busy_end"}, 64'(busy), 64'd0);
      check({tag, ".done_pulses"}, 64'(done_cnt - d0), 64'd1);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int wait_at, d0, nmis, ngap;
      int unsigned fc;
      logic [7:0] xs;
      tx_a.delete(); tx_d.delete(); got_q.delete(); got_t.delete();
      for (int i = 0; i < v.n; i++) begin
         tx_a.push_back(ADDR_W'(i));
         tx_d.push_back(v.base + 8'(i));
      end
      ack_rand = 1'b0;
      ack_lvl = v.ack;
      d0 = done_cnt;
      run_load(v.idx, v.honour, 1'b0, tag, wait_at, fc);
      finish_dl(d0, tag);
      check({tag, ".mem_ch"}, 64'(mem_ch), 64'(v.idx[1:0]));
      check({tag, ".byte_cnt"}, 64'(byte_cnt), 64'(v.exp_cnt));
      check({tag, ".xsum"}, 64'(xsum), 64'(v.exp_xsum));
      check({tag, ".err_ovf"}, 64'(err_ovf), 64'(v.exp_ovf));
      check({tag, ".wait_at"}, 64'(wait_at), 64'(v.exp_wait_at));
      check({tag, ".n_mem_wr"}, 64'(got_q.size()), 64'(v.exp_cnt));
      nmis = 0;
      for (int i = 0; i < v.exp_cnt && i < got_q.size(); i++) begin
         xs = v.base + 8'(i);
         if (got_q[i] !== {ADDR_W'(i), xs}) nmis++;
      end
      check({tag, ".order"}, 64'(nmis), 64'd0);
      if (v.chk_rate && got_t.size() > 0) begin
         check({tag, ".latency"}, 64'(got_t[0] - fc), 64'd2);
         ngap = 0;
         for (int k = 1; k < got_t.size(); k++) if (got_t[k] - got_t[k-1] != 2) ngap++;
         check({tag, ".rate"}, 64'(ngap), 64'd0);
      end
   endtask

   initial begin
      int wait_at, d0, bad, n, saw;
      int unsigned fc;
      logic [7:0] ch, sum;

      tab[0] = '{8'd1, 4,  8'h01, 1'b1, 1'b1, 4,  8'h0A, 1'b0, -1, 1'b1};
      tab[1] = '{8'd0, 1,  8'h5A, 1'b1, 1'b1, 1,  8'h5A, 1'b0, -1, 1'b1};
      tab[2] = '{8'd3, 4,  8'hF0, 1'b1, 1'b1, 4,  8'hC6, 1'b0, -1, 1'b1};
      tab[3] = '{8'd2, 20, 8'h01, 1'b0, 1'b1, 20, 8'hD2, 1'b0, 14, 1'b0};
      tab[4] = '{8'd3, 17, 8'h01, 1'b0, 1'b0, 16, 8'h88, 1'b1, 14, 1'b0};
      tab[5] = '{8'd1, 16, 8'h01, 1'b0, 1'b0, 16, 8'h88, 1'b0, 14, 1'b0};

      // reset state
      step; step;
      check("reset.outputs", 64'({mem_req, busy, done, err_ovf, ioctl_wait}), 64'd0);
      check("reset.byte_cnt", 64'(byte_cnt), 64'd0);
      check("reset.xsum", 64'(xsum), 64'd0);
      check("reset.mem_port", 64'({mem_addr, mem_data, mem_ch}), 64'd0);
      reset = 1'b0;
      step;

      // out-of-range index: download ignored entirely
      got_q.delete();
      d0 = done_cnt;
      saw = 0;
      ioctl_index = 8'd5;
      ioctl_download = 1'b1;
      step;
      for (int i = 0; i < 8; i++) begin
         ioctl_wr = 1'b1; ioctl_addr = ADDR_W'(i); ioctl_dout = 8'(i + 7);
         step;
         if (mem_req || busy || ioctl_wait) saw++;
      end
      ioctl_wr = 1'b0;
      ioctl_download = 1'b0;
      step; step; step;
      check("bad_idx.activity", 64'(saw), 64'd0);
      check("bad_idx.done", 64'(done_cnt - d0), 64'd0);
      check("bad_idx.byte_cnt", 64'(byte_cnt), 64'd0);

      foreach (tab[i]) run_vec(tab[i], $sformatf("vec%0d", i));

      // reset with a request pending, then a fresh download
      got_q.delete();
      ack_lvl = 1'b0;
      ioctl_index = 8'd2;
      ioctl_download = 1'b1;
      step;
      check("rst_mid.load", 64'(busy), 64'd1);
      for (int i = 0; i < 3; i++) begin
         ioctl_wr = 1'b1; ioctl_addr = ADDR_W'(100 + i); ioctl_dout = 8'(8'h30 + i);
         step;
      end
      ioctl_wr = 1'b0;
      step;
      check("rst_mid.pending", 64'(mem_req), 64'd1);
      reset = 1'b1;
      ioctl_download = 1'b0;
      step;
      check("rst_mid.mem_req", 64'(mem_req), 64'd0);
      check("rst_mid.busy", 64'(busy), 64'd0);
      check("rst_mid.byte_cnt", 64'(byte_cnt), 64'd0);
      check("rst_mid.wait", 64'(ioctl_wait), 64'd0);
      reset = 1'b0;
      step;
      check("rst_mid.no_write", 64'(got_q.size()), 64'd0);
      run_vec(tab[0], "after_rst");

      // second download arrives during DRAIN of an overflowed first one
      tx_a.delete(); tx_d.delete(); got_q.delete(); got_t.delete();
      for (int i = 0; i < 17; i++) begin
         tx_a.push_back(ADDR_W'(i + 64));
         tx_d.push_back(8'(i * 3));
      end
      ack_rand = 1'b0;
      ack_lvl = 1'b0;
      d0 = done_cnt;
      run_load(8'd0, 1'b0, 1'b0, "b2b.first", wait_at, fc);
      check("b2b.first_ovf", 64'(err_ovf), 64'd1);
      ioctl_download = 1'b0;
      step; step;
      ioctl_index = 8'd2;
      ioctl_download = 1'b1;
      step; step;
      check("b2b.wait_in_drain", 64'(ioctl_wait), 64'd1);
      check("b2b.busy_in_drain", 64'(busy), 64'd1);
      ack_lvl = 1'b1;
      saw = 0;
      for (int c = 0; c < 200 && busy; c++) begin
         if (!ioctl_wait) saw++;
         step;
      end
      check("b2b.wait_held", 64'(saw), 64'd0);
      for (int c = 0; c < 10 && !busy; c++) step;
      check("b2b.second_load", 64'(busy), 64'd1);
      check("b2b.first_done", 64'(done_cnt - d0), 64'd1);
      check("b2b.cleared", 64'({err_ovf, xsum, byte_cnt}), 64'd0);
      check("b2b.mem_ch", 64'(mem_ch), 64'd2);
      check("b2b.first_writes", 64'(got_q.size()), 64'd16);
      bad = 0;
      for (int i = 0; i < 16 && i < got_q.size(); i++) if (got_q[i] !== {tx_a[i], tx_d[i]}) bad++;
      check("b2b.first_order", 64'(bad), 64'd0);
      tx_a.delete(); tx_d.delete(); got_q.delete();
      tx_a.push_back(ADDR_W'(9)); tx_d.push_back(8'hC3);
      tx_a.push_back(ADDR_W'(3)); tx_d.push_back(8'h4D);
      d0 = done_cnt;
      run_load(8'd2, 1'b1, 1'b0, "b2b.second", wait_at, fc);
      finish_dl(d0, "b2b.second");
      check("b2b.second_cnt", 64'(byte_cnt), 64'd2);
      check("b2b.second_xsum", 64'(xsum), 64'h10);
      check("b2b.second_writes", 64'(got_q.size() == 2 && got_q[0] === {ADDR_W'(9), 8'hC3}
                                       && got_q[1] === {ADDR_W'(3), 8'h4D}), 64'd1);

      // randomized downloads against the queue model
      for (int r = 0; r < 20; r++) begin
         tx_a.delete(); tx_d.delete(); got_q.delete(); got_t.delete();
         n = $urandom_range(1, 40);
         ch = 8'($urandom_range(0, N_CH - 1));
         sum = '0;
         for (int i = 0; i < n; i++) begin
            tx_a.push_back(ADDR_W'($urandom));
            tx_d.push_back(8'($urandom));
            sum = sum + tx_d[i];
         end
         ack_rand = 1'b1;
         d0 = done_cnt;
         run_load(ch, 1'b1, 1'b1, $sformatf("rnd%0d", r), wait_at, fc);
         finish_dl(d0, $sformatf("rnd%0d", r));
         bad = (got_q.size() != n) ? 1 : 0;
         for (int i = 0; i < n && i < got_q.size(); i++) if (got_q[i] !== {tx_a[i], tx_d[i]}) bad++;
         check($sformatf("rnd%0d.stream", r), 64'(bad), 64'd0);
         check($sformatf("rnd%0d.summary", r), 64'({byte_cnt, xsum, err_ovf, mem_ch}),
               64'({ADDR_W'(n), sum, 1'b0, ch[1:0]}));
      end

      check("mem_port_stable", 64'(stab_err), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
